// File: rtl/clause_bitmap_builder.sv
// clause_bitmap_builder
// Accumulates clause hits into a CLAUSE_CHUNKS x INT_SIZE bitmap, then streams
// the bitmap out one word per accepted handshake.
//   Frame flow: start -> CLEAR (zero every word) -> ACCUM (take hits) ->
//   frame_done -> DRAIN (read out) -> IDLE (bitmap kept until next start).
// Ports:
//   clk, rst_flag (sync, active high), stop_flag (freeze), start (new frame)
//   in_valid/in_ready, clause_chunk, clause_pos[4:0] : hit input
//   frame_done                                        : end of hits
//   rd_valid/rd_ready, rd_addr, rd_data               : readout stream
//   done (1-cycle pulse), busy, err_range (sticky), hit_count
// Optional feature: define CLAUSE_BITMAP_POPCOUNT_EN to build the distinct-hit
// counter; otherwise hit_count is tied to zero.
module clause_bitmap_builder #(
    parameter int INT_SIZE      = 32,
    parameter int CLAUSE_CHUNKS = 63
) (
    input  logic                clk,
    input  logic                rst_flag,
    input  logic                stop_flag,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         clause_chunk,
    input  logic [31:0]         clause_pos,
    input  logic                frame_done,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [5:0]          rd_addr,
    output logic [INT_SIZE-1:0] rd_data,
    output logic                done,
    output logic                busy,
    output logic                err_range,
    output logic [15:0]         hit_count
);
    localparam int IDX_W = (CLAUSE_CHUNKS > 1) ? $clog2(CLAUSE_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLAUSE_CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DRAIN} state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   index_reg, index_next;
    logic               done_reg, done_next;
    logic               err_range_reg;
    logic [INT_SIZE-1:0] words [CLAUSE_CHUNKS];

    // Normal operation only when neither freeze nor restart overrides it.
    logic               run;
    logic               hit_fire;
    logic               hit_in_range;
    logic               hit_wr;
    logic [IDX_W-1:0]   hit_idx;
    logic [INT_SIZE-1:0] hit_mask;
    logic               unused_pos;

    assign run          = !stop_flag && !start;
    assign in_ready     = (state_reg == ACCUM) && !stop_flag;
    // start outranks a hit presented in the same cycle: the hit is dropped.
    assign hit_fire     = in_valid && in_ready && !start;
    assign hit_in_range = clause_chunk < 32'(CLAUSE_CHUNKS);
    assign hit_idx      = clause_chunk[IDX_W-1:0];
    assign hit_mask     = INT_SIZE'(1) << clause_pos[4:0];
    assign hit_wr       = hit_fire && hit_in_range;
    assign unused_pos   = ^clause_pos[31:5];

    // One register per bitmap word; CLEAR and hit writes never overlap because
    // they belong to different states.
    genvar gi;
    generate
        for (gi = 0; gi < CLAUSE_CHUNKS; gi++) begin : g_word
            logic [INT_SIZE-1:0] word_reg;
            always_ff @(posedge clk) begin
                if (rst_flag) begin
                    word_reg <= '0;
                end else if (run) begin
                    if (state_reg == CLEAR && index_reg == IDX_W'(gi))
                        word_reg <= '0;
                    else if (hit_wr && hit_idx == IDX_W'(gi))
                        word_reg <= word_reg | hit_mask;
                end
            end
            assign words[gi] = word_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst_flag) begin
            state_reg <= IDLE;
            index_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        done_next  = 1'b0;
        if (stop_flag) begin
            // frozen: hold state and index
        end else if (start) begin
            state_next = CLEAR;
            index_next = '0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    if (index_reg == LAST_IDX) begin
                        state_next = ACCUM;
                        index_next = '0;
                    end else begin
                        index_next = index_reg + 1'b1;
                    end
                end
                ACCUM: begin
                    if (frame_done) begin
                        state_next = DRAIN;
                        index_next = '0;
                    end
                end
                DRAIN: begin
                    if (rd_ready) begin
                        if (index_reg == LAST_IDX) begin
                            state_next = IDLE;
                            index_next = '0;
                            done_next  = 1'b1;
                        end else begin
                            index_next = index_reg + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_flag)
            err_range_reg <= 1'b0;
        else if (!stop_flag) begin
            if (start)
                err_range_reg <= 1'b0;
            else if (hit_fire && !hit_in_range)
                err_range_reg <= 1'b1;
        end
    end

`ifdef CLAUSE_BITMAP_POPCOUNT_EN
    logic [15:0] hit_count_reg;
    logic        hit_new;

    // Only a 0->1 transition of the targeted bit counts as a distinct hit.
    assign hit_new = ((words[hit_idx] & hit_mask) == '0);

    always_ff @(posedge clk) begin
        if (rst_flag)
            hit_count_reg <= 16'h0000;
        else if (!stop_flag) begin
            if (start)
                hit_count_reg <= 16'h0000;
            else if (hit_wr && hit_new && hit_count_reg != 16'hFFFF)
                hit_count_reg <= hit_count_reg + 16'd1;
        end
    end
    assign hit_count = hit_count_reg;
`else
    assign hit_count = 16'h0000;
`endif

    assign rd_valid  = (state_reg == DRAIN) && !stop_flag;
    assign rd_addr   = (state_reg == DRAIN) ? 6'(index_reg) : 6'd0;
    assign rd_data   = (state_reg == DRAIN) ? words[index_reg] : '0;
    assign done      = done_reg && !stop_flag;
    assign busy      = (state_reg != IDLE);
    assign err_range = err_range_reg;

endmodule

// File: tb/tb_clause_bitmap_builder.sv
// Testbench for clause_bitmap_builder: directed frames, scoreboard of expected
// readout words consumed by a negedge monitor.
module tb_clause_bitmap_builder;
    logic        clk = 1'b0;
    logic        rst_flag = 1'b0, stop_flag = 1'b0, start = 1'b0;
    logic        in_valid = 1'b0, frame_done = 1'b0, rd_ready = 1'b0;
    logic        in_ready, rd_valid, done, busy, err_range;
    logic [31:0] clause_chunk = '0, clause_pos = '0;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic [15:0] hit_count;

    always #5 clk = ~clk;

    clause_bitmap_builder #(.INT_SIZE(32), .CLAUSE_CHUNKS(63)) dut (
        .clk(clk), .rst_flag(rst_flag), .stop_flag(stop_flag), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .clause_chunk(clause_chunk),
        .clause_pos(clause_pos), .frame_done(frame_done), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data), .done(done),
        .busy(busy), .err_range(err_range), .hit_count(hit_count)
    );

`ifdef CLAUSE_BITMAP_POPCOUNT_EN
    localparam logic [31:0] HC3 = 32'd3;
`else
    localparam logic [31:0] HC3 = 32'd0;
`endif

    typedef struct { int addr; logic [31:0] data; } rd_t;
    rd_t         exp_q[$];
    logic [31:0] exp_map [63];
    int          tests = 0, fails = 0, done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted readout word is compared against the queue.
    always @(negedge clk) begin
        rd_t e;
        if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_read: got addr %0d data %0h, expected none", rd_addr, rd_data);
            end else begin
                e = exp_q.pop_front();
                check("rd_addr", 32'(rd_addr), 32'(e.addr));
                check("rd_data", rd_data, e.data);
            end
        end
        if (done) done_cnt++;
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic do_start;
        start = 1'b1; tick; start = 1'b0;
        for (int i = 0; i < 63; i++) exp_map[i] = '0;
    endtask

    task automatic wait_ready(input int stop_lo, input int stop_hi, output int n);
        n = 0;
        while (!in_ready && n < 300) begin
            stop_flag = (n >= stop_lo && n < stop_hi);
            tick;
            n++;
        end
        stop_flag = 1'b0;
    endtask

    task automatic hit(input int c, input int p, input bit fd);
        in_valid = 1'b1; clause_chunk = 32'(c); clause_pos = 32'(p); frame_done = fd;
        tick;
        in_valid = 1'b0; frame_done = 1'b0;
    endtask

    task automatic push_frame(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{i, exp_map[i]});
    endtask

    // Drain until done; optional stop window and rd_ready pattern 1,0,0,1,1...
    task automatic drain(input int stop_lo, input int stop_hi, input bit stall, output int cyc);
        int acc;
        acc = 0; cyc = 0;
        while (!done && cyc < 400) begin
            stop_flag = (cyc >= stop_lo && cyc < stop_hi);
            rd_ready  = !(stall && (cyc == 1 || cyc == 2));
            #1;
            if (!rd_ready && rd_valid) begin
                check("stall_addr", 32'(rd_addr), 32'(acc));
                check("stall_data", rd_data, exp_map[acc]);
            end
            if (stop_flag) check("stop_rd_valid", 32'(rd_valid), 32'd0);
            if (rd_valid && rd_ready) acc++;
            tick;
            cyc++;
        end
        stop_flag = 1'b0; rd_ready = 1'b0;
        check("accept_count", 32'(acc), 32'd63);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, cyc, d0;

        // Reset state
        rst_flag = 1'b1; tick; tick; rst_flag = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err_range), 0);
        check("rst_hit_count", 32'(hit_count), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_rd_data", rd_data, 0);

        // Empty frame: CLEAR length, all-zero readout
        do_start;
        check("start_busy", 32'(busy), 1);
        wait_ready(-1, -1, n);
        check("clear_cycles", 32'(n), 32'd63);
        frame_done = 1'b1; tick; frame_done = 1'b0;
        push_frame(63);
        drain(-1, -1, 1'b0, cyc);
        check("drain_cycles_plain", 32'(cyc), 32'd63);
        check("idle_busy", 32'(busy), 0);

        // Hits, duplicate, out-of-range, hit with frame_done, stalled drain
        do_start;
        wait_ready(-1, -1, n);
        hit(0, 0, 0); hit(1, 31, 0); hit(1, 31, 0);
        hit(63, 0, 0); hit(100, 7, 0);
        check("err_range_set", 32'(err_range), 1);
        check("hit_count_mid", 32'(hit_count), (HC3 == 0) ? 32'd0 : 32'd2);
        hit(62, 5, 1);
        check("hit_count", 32'(hit_count), HC3);
        exp_map[0] = 32'h0000_0001; exp_map[1] = 32'h8000_0000; exp_map[62] = 32'h0000_0020;
        push_frame(63);
        d0 = done_cnt;
        drain(-1, -1, 1'b1, cyc);
        check("drain_cycles_stall", 32'(cyc), 32'd65);
        tick; tick;
        check("done_once", 32'(done_cnt - d0), 1);
        check("done_low_after", 32'(done), 0);
        check("stall_busy", 32'(busy), 0);
        check("err_sticky", 32'(err_range), 1);
        do_start;
        check("err_cleared", 32'(err_range), 0);
        check("hit_count_cleared", 32'(hit_count), 0);

        // stop_flag in CLEAR and in DRAIN
        do_start;
        wait_ready(10, 15, n);
        check("clear_cycles_stop", 32'(n), 32'd68);
        hit(5, 3, 1);
        exp_map[5] = 32'h0000_0008;
        push_frame(63);
        drain(20, 25, 1'b0, cyc);
        check("drain_cycles_stop", 32'(cyc), 32'd68);

        // Abort DRAIN at index 10 with start
        do_start;
        wait_ready(-1, -1, n);
        hit(2, 2, 1);
        exp_map[2] = 32'h0000_0004;
        push_frame(10);
        rd_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        rd_ready = 1'b0; #1;
        check("abort_addr", 32'(rd_addr), 32'd10);
        d0 = done_cnt;
        start = 1'b1; tick; start = 1'b0;
        check("abort_rd_valid", 32'(rd_valid), 0);
        check("abort_busy", 32'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("abort_no_done", 32'(done), 0);
        end
        wait_ready(-1, -1, n);
        check("abort_clear_cycles", 32'(n), 32'd60);
        check("abort_done_cnt", 32'(done_cnt - d0), 0);

        // Reset during ACCUM
        hit(70, 0, 0);
        check("err_before_rst", 32'(err_range), 1);
        rst_flag = 1'b1; tick; rst_flag = 1'b0;
        check("accum_rst_busy", 32'(busy), 0);
        check("accum_rst_in_ready", 32'(in_ready), 0);
        check("accum_rst_err", 32'(err_range), 0);
        check("accum_rst_rd_valid", 32'(rd_valid), 0);
        frame_done = 1'b1; tick; frame_done = 1'b0;
        check("idle_frame_done_ignored", 32'(busy), 0);

        tick;
        check("queue_empty", 32'(exp_q.size()), 0);
        check("total_done", 32'(done_cnt), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
